// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg
//   Shared constants for the hardwired control unit: opcode values (IR[31:27]),
//   ALU function codes, T-state encodings and the strobe vector produced by the
//   decoder. Also holds small helpers that classify an opcode and find the last
//   T-state of its instruction.
// Ports: none (package).
package control_sequencer_pkg;

  localparam int OPC_W   = 5;
  localparam int ALUOP_W = 4;

  // Opcodes
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_JR   = 5'b10011;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11001;

  // ALU function codes
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0011;

  // T-state encoding; codes 0001..0110 are unused and recover to RESET.
  typedef enum logic [3:0] {
    ST_RESET = 4'b0000,
    ST_T0    = 4'b0111,
    ST_T1    = 4'b1000,
    ST_T2    = 4'b1001,
    ST_T3    = 4'b1010,
    ST_T4    = 4'b1011,
    ST_T5    = 4'b1100,
    ST_T6    = 4'b1101,
    ST_T7    = 4'b1110,
    ST_HALT  = 4'b1111
  } state_e;

  // Instruction classes sharing the same execute sequence.
  typedef enum logic [3:0] {
    CLS_LD   = 4'd0,
    CLS_LDI  = 4'd1,
    CLS_ST   = 4'd2,
    CLS_ALU  = 4'd3,
    CLS_ADDI = 4'd4,
    CLS_JR   = 4'd5,
    CLS_NOP  = 4'd6,
    CLS_HALT = 4'd7,
    CLS_ILL  = 4'd8
  } op_class_e;

  // Live strobes; the reserved mul/div, branch and I/O strobes are tied off in the top.
  typedef struct packed {
    logic               pc_out;
    logic               zlow_out;
    logic               zhigh_out;
    logic               mdr_out;
    logic               ba_out;
    logic               c_out;
    logic               r_out;
    logic               pc_in;
    logic               ir_in;
    logic               mar_in;
    logic               mdr_in;
    logic               y_in;
    logic               zlow_in;
    logic               zhigh_in;
    logic               r_in;
    logic               inc_pc;
    logic               read;
    logic               ram_we;
    logic               gra;
    logic               grb;
    logic               grc;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  function automatic op_class_e op_class(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_LD:                           return CLS_LD;
      OPC_LDI:                          return CLS_LDI;
      OPC_ST:                           return CLS_ST;
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: return CLS_ALU;
      OPC_ADDI:                         return CLS_ADDI;
      OPC_JR:                           return CLS_JR;
      OPC_NOP:                          return CLS_NOP;
      OPC_HALT:                         return CLS_HALT;
      default:                          return CLS_ILL;
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] alu_sel(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_SUB: return ALU_SUB;
      OPC_AND: return ALU_AND;
      OPC_OR:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  // Last T-state of each instruction class; the boundary where stop is honoured.
  function automatic state_e final_state(input op_class_e cls);
    case (cls)
      CLS_LD, CLS_ST:            return ST_T7;
      CLS_LDI, CLS_ALU, CLS_ADDI: return ST_T5;
      default:                   return ST_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Groups the sequencer's instruction inputs (opcode, stop), status outputs
//   (run, illegal, alu_op) and all datapath control strobes.
//   master : the control sequencer (drives status and strobes)
//   slave  : the datapath side (drives opcode/stop, consumes strobes)
//   mon    : passive observer (everything as input)
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic [OPC_W-1:0]   opcode;
  logic               stop;
  logic               run;
  logic               illegal;
  logic [ALUOP_W-1:0] alu_op;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, BAout, Cout, Rout, InPortout;
  logic PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortIn;
  logic IncPC, Read, ramWE, Gra, Grb, Grc;

  modport master (
    input  opcode, stop,
    output run, illegal, alu_op,
    output PCout, ZLowout, ZHighout, MDRout, HIout, LOout, BAout, Cout, Rout, InPortout,
    output PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortIn,
    output IncPC, Read, ramWE, Gra, Grb, Grc
  );

  modport slave (
    output opcode, stop,
    input  run, illegal, alu_op,
    input  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, BAout, Cout, Rout, InPortout,
    input  PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortIn,
    input  IncPC, Read, ramWE, Gra, Grb, Grc
  );

  modport mon (
    input opcode, stop, run, illegal, alu_op,
    input PCout, ZLowout, ZHighout, MDRout, HIout, LOout, BAout, Cout, Rout, InPortout,
    input PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortIn,
    input IncPC, Read, ramWE, Gra, Grb, Grc
  );

endinterface

// File: rtl/control_sequencer_chk.sv
// control_sequencer_chk
//   Protocol checker for the control sequencer strobes.
//   clk  in   clock
//   clr  in   active-low reset (checks disabled while low)
//   bus  mon modport of the sequencer interface
module control_sequencer_chk (
  input logic               clk,
  input logic               clr,
  control_sequencer_if.mon  bus
);

  // Only one bus driver may be enabled at a time.
  a_bus_excl: assert property (@(posedge clk) disable iff (!clr)
    $countones({bus.PCout, bus.ZLowout, bus.ZHighout, bus.MDRout, bus.HIout,
                bus.LOout, bus.BAout, bus.Cout, bus.Rout, bus.InPortout}) <= 1);

  // Register-select lines are one-hot or idle.
  a_reg_sel: assert property (@(posedge clk) disable iff (!clr)
    $countones({bus.Gra, bus.Grb, bus.Grc}) <= 1);

endmodule

// File: rtl/control_sequencer_decode.sv
// control_sequencer_decode
//   Purely combinational: current T-state plus latched opcode -> strobe vector.
//   state   in   T-state register value
//   opc     in   opcode captured at the T2->T3 edge
//   ctrl    out  strobe vector and alu_op
//   run     out  1 in T0..T7
//   illegal out  1 in T3 when the opcode is undefined
module control_sequencer_decode
  import control_sequencer_pkg::*;
(
  input  state_e           state,
  input  logic [OPC_W-1:0] opc,
  output ctrl_t            ctrl,
  output logic             run,
  output logic             illegal
);

  op_class_e cls;
  assign cls = op_class(opc);

  // Moore strobe decode; every state/class combination not listed leaves all strobes low.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    run         = 1'b0;
    illegal     = 1'b0;
    case (state)
      ST_T0: begin
        run = 1'b1;
        ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.zlow_in = 1'b1;
      end
      ST_T1: begin
        run = 1'b1;
        ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
      end
      ST_T2: begin
        run = 1'b1;
        ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
      end
      ST_T3: begin
        run = 1'b1;
        case (cls)
          // Effective address base goes through BAout so R0 reads as zero.
          CLS_LD, CLS_LDI, CLS_ST: begin
            ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
          end
          CLS_ALU, CLS_ADDI: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
          end
          CLS_JR: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
          end
          CLS_ILL: illegal = 1'b1;
          default: ;
        endcase
      end
      ST_T4: begin
        run = 1'b1;
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST, CLS_ADDI: begin
            ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1; ctrl.zhigh_in = 1'b1;
          end
          CLS_ALU: begin
            ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.zlow_in = 1'b1; ctrl.zhigh_in = 1'b1;
            ctrl.alu_op = alu_sel(opc);
          end
          default: ;
        endcase
      end
      ST_T5: begin
        run = 1'b1;
        case (cls)
          CLS_LD, CLS_ST: begin
            ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
          end
          CLS_LDI, CLS_ALU, CLS_ADDI: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        run = 1'b1;
        case (cls)
          CLS_LD: begin
            ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
          end
          // Read stays low so MDR captures the bus (store data) rather than memory.
          CLS_ST: begin
            ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        run = 1'b1;
        case (cls)
          CLS_LD: begin
            ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          CLS_ST:  ctrl.ram_we = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hardwired Moore control unit: fetch T0-T2, decode at T3, execute, then back
//   to T0 or park in HALT. Outputs are decoded combinationally from the state
//   register so clr forces them low immediately.
//   clk  in   clock, rising edge
//   clr  in   asynchronous active-low reset
//   bus  master modport: opcode/stop in; run, illegal, alu_op and strobes out
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPC_W_P         = OPC_W,
  parameter int ALUOP_W_P       = ALUOP_W,
  parameter bit STOP_ON_ILLEGAL = 1'b0
) (
  input  logic                 clk,
  input  logic                 clr,
  control_sequencer_if.master  bus
);

  state_e             state_r;
  state_e             state_n;
  logic [OPC_W_P-1:0] opc_r;
  op_class_e          cls;
  logic               at_end;
  logic               park;
  ctrl_t              ctrl;
  logic               run;
  logic               illegal;

  // T-state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_r <= ST_RESET;
    else      state_r <= state_n;
  end

  // Opcode is captured once, on the edge into T3, so IR may change afterwards.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                   opc_r <= '0;
    else if (state_r == ST_T2)  opc_r <= bus.opcode;
    else                        opc_r <= opc_r;
  end

  assign cls = op_class(opc_r);

  // Next-state: stop and halt/illegal parking are only evaluated in the instruction's last state.
  always_comb begin
    state_n = ST_RESET;
    at_end  = (state_r == final_state(cls));
    park    = (cls == CLS_HALT) || ((cls == CLS_ILL) && STOP_ON_ILLEGAL) || bus.stop;
    case (state_r)
      ST_RESET: state_n = ST_T0;
      ST_T0:    state_n = ST_T1;
      ST_T1:    state_n = ST_T2;
      ST_T2:    state_n = ST_T3;
      ST_T3:    state_n = at_end ? (park ? ST_HALT : ST_T0) : ST_T4;
      ST_T4:    state_n = at_end ? (park ? ST_HALT : ST_T0) : ST_T5;
      ST_T5:    state_n = at_end ? (park ? ST_HALT : ST_T0) : ST_T6;
      ST_T6:    state_n = at_end ? (park ? ST_HALT : ST_T0) : ST_T7;
      ST_T7:    state_n = park ? ST_HALT : ST_T0;
      ST_HALT:  state_n = ST_HALT;
      default:  state_n = ST_RESET;
    endcase
  end

  control_sequencer_decode u_decode (
    .state   (state_r),
    .opc     (opc_r),
    .ctrl    (ctrl),
    .run     (run),
    .illegal (illegal)
  );

  assign bus.run       = run;
  assign bus.illegal   = illegal;
  assign bus.alu_op    = ctrl.alu_op;
  assign bus.PCout     = ctrl.pc_out;
  assign bus.ZLowout   = ctrl.zlow_out;
  assign bus.ZHighout  = ctrl.zhigh_out;
  assign bus.MDRout    = ctrl.mdr_out;
  assign bus.BAout     = ctrl.ba_out;
  assign bus.Cout      = ctrl.c_out;
  assign bus.Rout      = ctrl.r_out;
  assign bus.PCin      = ctrl.pc_in;
  assign bus.IRin      = ctrl.ir_in;
  assign bus.MARin     = ctrl.mar_in;
  assign bus.MDRin     = ctrl.mdr_in;
  assign bus.Yin       = ctrl.y_in;
  assign bus.ZLowIn    = ctrl.zlow_in;
  assign bus.ZHighIn   = ctrl.zhigh_in;
  assign bus.Rin       = ctrl.r_in;
  assign bus.IncPC     = ctrl.inc_pc;
  assign bus.Read      = ctrl.read;
  assign bus.ramWE     = ctrl.ram_we;
  assign bus.Gra       = ctrl.gra;
  assign bus.Grb       = ctrl.grb;
  assign bus.Grc       = ctrl.grc;
  // Reserved for mul/div, branch and I/O.
  assign bus.HIout     = 1'b0;
  assign bus.LOout     = 1'b0;
  assign bus.InPortout = 1'b0;
  assign bus.HIin      = 1'b0;
  assign bus.LOin      = 1'b0;
  assign bus.CONin     = 1'b0;
  assign bus.OutPortIn = 1'b0;

endmodule
